parity_arbiter: RTL and testbench



---
 rtl/parity_arbiter_pkg.sv | 15 +
 rtl/odd_even2.sv | 11 +
 rtl/parity_arbiter.sv | 139 +++++++++++++
 tb/tb_parity_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_arbiter_pkg.sv
// Shared types and constants for the round-robin parity arbiter.
package parity_arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Requester ids as carried on res_id and held in last_grant.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/odd_even2.sv
// Two-input parity cell: odd is high when exactly one input is high.
module odd_even2 (
  input  logic a,
  input  logic b,
  output logic odd
);

  // Single-step parity fold.
  assign odd = a ^ b;

endmodule

// File: rtl/parity_arbiter.sv
// Two-requester round-robin front end for one serial parity engine. The granted
// word is folded one bit per cycle through an odd_even2 cell, and the result is
// returned tagged with the requester id over a valid/ready channel.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_parity,
  output logic             res_id,
  input  logic             res_ready
);

  // Reject illegal parameterisations at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("parity_arbiter: WIDTH must lie in 2..32");
  end
  if (CNT_W != $clog2(WIDTH)) begin : g_cnt_w_check
    $error("parity_arbiter: CNT_W must equal ceil(log2(WIDTH))");
  end

  // Count value on the edge that folds the last bit.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_id_q;
  logic             last_grant_q;
  logic             res_valid_q;

  logic             grant0;
  logic             grant1;
  logic             acc_step;

  // Round-robin grant decision; only meaningful while idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && (!req1_valid || last_grant_q == REQ1)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Readies are forced low while reset is held so nothing is accepted then.
  assign req0_ready = grant0 & reset_n;
  assign req1_ready = grant1 & reset_n;

  // The only parity gate: folds the next LSB into the accumulator.
  odd_even2 u_step (
    .a   (acc_q),
    .b   (sr_q[0]),
    .odd (acc_step)
  );

  // Arbiter FSM with its datapath registers and registered result flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      res_id_q     <= REQ0;
      last_grant_q <= REQ1;
      res_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            sr_q     <= grant0 ? req0_data : req1_data;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            res_id_q <= grant0 ? REQ0 : REQ1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          acc_q <= acc_step;
          sr_q  <= sr_q >> 1;
          if (cnt_q == LastCnt) begin
            // Hold the count on the final fold so it never wraps.
            state_q     <= StDone;
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            last_grant_q <= res_id_q;
            res_valid_q  <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result channel; parity is only exposed alongside a valid result.
  assign res_valid  = res_valid_q;
  assign res_parity = res_valid_q & acc_q;
  assign res_id     = res_id_q;

  // At most one requester is accepted per cycle.
  a_one_ready : assert property (@(posedge clk) disable iff (!reset_n)
    !(req0_ready && req1_ready));

  // A stalled result must hold steady until taken.
  a_res_hold : assert property (@(posedge clk) disable iff (!reset_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_parity) && $stable(res_id)));

  // Nothing is accepted while a result is in flight or pending.
  a_no_grant_busy : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q != StIdle) |-> !(req0_ready || req1_ready));

  // res_valid tracks the DONE state exactly.
  a_valid_done : assert property (@(posedge clk) disable iff (!reset_n)
    res_valid == (state_q == StDone));

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed-vector bench for parity_arbiter with hand-computed parities.
module tb_parity_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             reset_n;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_parity;
  logic             res_id;
  logic             res_ready;

  int n_vec  = 0;
  int n_miss = 0;

  parity_arbiter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_parity (res_parity),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits on negedges until res_valid, returning how many edges it took.
  task automatic wait_result(input int max_cycles, output int lat);
    lat = 0;
    while (!res_valid && lat < max_cycles) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge in IDLE: submit one word, check grant, latency, result.
  task automatic run_word(input logic id, input logic [7:0] data, input logic exp_par,
                          input string tag);
    int lat;
    res_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = data;
    end else begin
      req0_valid = 1'b1;
      req0_data  = data;
    end
    #1;
    check_eq({tag, "_ready"}, 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq({tag, "_ready_drop"}, 32'({req1_ready, req0_ready}), 32'd0);
    wait_result(3 * WIDTH, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check_eq({tag, "_parity"}, 32'(res_parity), 32'(exp_par));
    check_eq({tag, "_id"}, 32'(res_id), 32'(id));
    @(negedge clk);
    check_eq({tag, "_consumed"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int got;
    int cyc;
    int res_cyc[4];
    logic bad;

    reset_n    = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    res_ready  = 1'b0;

    // Reset pulse mid-cycle; a valid request must not see ready while in reset.
    #3;
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    #1;
    check_eq("rst_outputs", 32'({req0_ready, req1_ready, res_valid, res_parity, res_id}),
             32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    reset_n    = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ({req0_ready, req1_ready, res_valid, res_parity, res_id} != 5'd0) bad = 1'b1;
    end
    check_eq("idle_10", 32'(bad), 32'd0);

    // Single request: 0xB5 has five ones.
    run_word(1'b0, 8'hB5, 1'b1, "single");

    // Fresh reset so contention starts with requester 0.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'h03;
    req1_valid = 1'b1;
    req1_data  = 8'h07;
    res_ready  = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        check_eq($sformatf("cont_id%0d", got), 32'(res_id), 32'(got % 2));
        check_eq($sformatf("cont_par%0d", got), 32'(res_parity), 32'(got % 2));
        res_cyc[got] = cyc;
        got++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("cont_count", 32'(got), 32'd4);
    check_eq("cont_first", 32'(res_cyc[0]), 32'd9);
    for (int i = 1; i < 4; i++) begin
      if (i < got) check_eq($sformatf("cont_gap%0d", i), 32'(res_cyc[i] - res_cyc[i-1]), 32'd10);
    end

    // Back-pressure: 0x2A (three ones) from requester 1, held for 5 cycles.
    @(negedge clk);
    res_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'h2A;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h00;
    wait_result(3 * WIDTH, lat);
    check_eq("bp_latency", 32'(lat), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_hold%0d", i),
               32'({res_valid, res_parity, res_id, req0_ready, req1_ready}), 32'b11100);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_taken", 32'(res_valid), 32'd0);
    check_eq("bp_next_ready", 32'({req1_ready, req0_ready}), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_result(3 * WIDTH, lat);
    check_eq("bp_next_lat", 32'(lat), 32'(WIDTH));
    check_eq("bp_next_res", 32'({res_id, res_parity}), 32'd0);
    @(negedge clk);

    // Reset in the 4th SHIFT cycle of 0xFF; in-flight word must vanish.
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n    = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'h01;
    #1;
    check_eq("midrst_outputs", 32'({req0_ready, req1_ready, res_valid, res_parity, res_id}),
             32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_word(1'b1, 8'h01, 1'b1, "post_rst");

    // Edge data patterns.
    run_word(1'b0, 8'h00, 1'b0, "zero");
    run_word(1'b0, 8'hFF, 1'b0, "ones");
    run_word(1'b0, 8'h80, 1'b1, "msb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
